// File: rtl/snake_hardware_buttons_pkg.sv
// Shared constants and elaboration helpers for the snake button controller.
// No logic; no latency.
// No handshake.
// Contents: register word addresses, default button count, and the debounce counter-width and range helpers.
package snake_buttons_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_RSVD     = 2'd2;
  localparam logic [1:0] ADDR_EDGE     = 2'd3;

  localparam int DEFAULT_WIDTH = 4;

  // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
  function automatic int cnt_width(input int dc);
    return $clog2(dc);
  endfunction

  function automatic bit debounce_cycles_ok(input int dc);
    return (dc >= 2) && (dc <= (1 << 20));
  endfunction

endpackage

// File: rtl/snake_hardware_buttons_if.sv
// Avalon-MM slave bus plus interrupt line for the button controller.
// No logic; no latency.
// Zero wait states; there is no waitrequest, so the slave accepts every access.
// Signals: address[1:0], chipselect, write_n (active-low), writedata[31:0] (master -> slave);
//          readdata[31:0], irq (slave -> master).
interface snake_hardware_buttons_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/snake_hardware_buttons_debounce.sv
// One-bit button conditioner: 2-flop synchronizer followed by an optional debounce counter.
// Latency: 2+DEBOUNCE_CYCLES edges with SNAKE_HARDWARE_BUTTONS_DEBOUNCE_EN defined, otherwise 2 edges.
// No backpressure; the input is sampled every cycle.
// Ports: clk, reset_n (async active-low), din (raw asynchronous level), stable (conditioned level).
// Macro SNAKE_HARDWARE_BUTTONS_DEBOUNCE_EN selects the counter; without it stable is the synchronizer output.
module snake_button_debounce
  import snake_buttons_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  if (!debounce_cycles_ok(DEBOUNCE_CYCLES)) begin : g_bad_cycles
    $error("snake_button_debounce: DEBOUNCE_CYCLES must lie in 2..2^20");
  end

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef SNAKE_HARDWARE_BUTTONS_DEBOUNCE_EN
  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             stable_q;

  // Any cycle where sync2 agrees with stable restarts the count, so only an
  // uninterrupted run of DEBOUNCE_CYCLES disagreeing cycles flips stable.
  // The count stops at CNT_LAST and clears, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      stable_q <= 1'b0;
    end else if (sync2 == stable_q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt      <= '0;
      stable_q <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync2;
`endif

endmodule

// File: rtl/snake_hardware_buttons.sv
// Avalon-MM button controller: debounced levels, rising-edge capture with W1C, maskable level irq.
// Latency: DATA follows in_port after 2+DEBOUNCE_CYCLES edges (2 without debounce); capture one edge later.
// Zero-wait-state slave: readdata is combinational, writes complete on the strobe edge.
// Ports: clk, reset_n (async active-low), bus (snake_hardware_buttons_if.slave), in_port[WIDTH-1:0].
// Macro SNAKE_HARDWARE_BUTTONS_DEBOUNCE_EN enables per-bit debounce counters.
module snake_hardware_buttons
  import snake_buttons_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  snake_hardware_buttons_if.slave  bus,
  input  logic [WIDTH-1:0]         in_port
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_clr;
  logic             wr_en;
  logic [31:0]      rdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    snake_button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .stable  (stable[i])
    );
  end

  // Register bits above WIDTH have no storage behind them.
  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = |bus.writedata[31:WIDTH];
  end

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign rise     = stable & ~stable_d;
  assign edge_clr = (wr_en && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      stable_d <= stable;
      if (wr_en && (bus.address == ADDR_IRQ_MASK)) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      // OR-ing rise after the clear lets a same-edge capture beat the W1C.
      edge_cap <= (edge_cap & ~edge_clr) | rise;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA:     rdata[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: rdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE:     rdata[WIDTH-1:0] = edge_cap;
      default:       rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  // Built only from flops, so irq cannot glitch on input or bus activity.
  assign bus.irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_snake_hardware_buttons.sv
module tb_snake_hardware_buttons;

  localparam int WIDTH = 4;
  localparam int DC    = 4;
`ifdef SNAKE_HARDWARE_BUTTONS_DEBOUNCE_EN
  localparam int         LAT = 2 + DC;
  localparam int         MID = 4;      // bit-3 counter has reached 2
  localparam logic [3:0] P1  = 4'h1;
`else
  localparam int         LAT = 2;
  localparam int         MID = 1;
  localparam logic [3:0] P1  = 4'hA;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;

  snake_hardware_buttons_if bus ();

  snake_hardware_buttons #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_head(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", t, obs, e);
    end
  endtask

  task automatic expect_reg(input logic [1:0] a, input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    bus.address = a;
    #1;
    compare_head(bus.readdata);
  endtask

  task automatic expect_irq(input logic e, input string t);
    exp_q.push_back({31'd0, e});
    tag_q.push_back(t);
    #1;
    compare_head({31'd0, bus.irq});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    in_port        = '0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    // Reset state
    tick(3);
    for (int a = 0; a < 4; a++) expect_reg(2'(a), 32'd0, "in_reset_read");
    expect_irq(1'b0, "in_reset_irq");
    reset_n = 1'b1;
    tick(1);
    for (int a = 0; a < 4; a++) expect_reg(2'(a), 32'd0, "post_reset_read");
    expect_irq(1'b0, "post_reset_irq");

    // Clean press: DATA at edge LAT, capture at LAT+1
    in_port = P1;
    tick(LAT - 1);
    expect_reg(2'd0, 32'd0, "data_before_latency");
    tick(1);
    expect_reg(2'd0, {28'd0, P1}, "data_at_latency");
    expect_reg(2'd3, 32'd0, "edge_before_capture");
    tick(1);
    expect_reg(2'd3, {28'd0, P1}, "edge_captured");
    expect_irq(1'b0, "irq_masked_off");
    wr(2'd1, {28'd0, P1});
    expect_irq(1'b1, "irq_after_mask_write");

    // W1C with zero, masking, upper writedata bits, reserved address
    wr(2'd3, 32'd0);
    expect_reg(2'd3, {28'd0, P1}, "w1c_zero_no_effect");
    wr(2'd1, 32'd0);
    expect_irq(1'b0, "irq_mask_cleared");
    expect_reg(2'd3, {28'd0, P1}, "mask_keeps_edge");
    wr(2'd1, {28'hFFFFFFF, P1});
    expect_reg(2'd1, {28'd0, P1}, "mask_upper_bits_ignored");
    expect_irq(1'b1, "irq_mask_restored");
    wr(2'd2, 32'hFFFFFFFF);
    expect_reg(2'd2, 32'd0, "reserved_reads_zero");

`ifdef SNAKE_HARDWARE_BUTTONS_DEBOUNCE_EN
    // 3-cycle glitch on bit 2 must be rejected
    in_port = P1 | 4'h4;
    tick(3);
    in_port = P1;
    tick(8);
    expect_reg(2'd0, {28'd0, P1}, "glitch_data");
    expect_reg(2'd3, {28'd0, P1}, "glitch_edge");
`endif

    // Release: falling edge not captured
    in_port = '0;
    tick(LAT + 1);
    expect_reg(2'd0, 32'd0, "release_data");
    expect_reg(2'd3, {28'd0, P1}, "fall_not_captured");

    // Press again and clear on the capture edge: set wins
    in_port = P1;
    tick(LAT);
    wr(2'd3, {28'd0, P1});
    expect_reg(2'd3, {28'd0, P1}, "set_beats_clear");
    expect_irq(1'b1, "irq_set_beats_clear");
    tick(3);
    wr(2'd3, {28'd0, P1});
    expect_reg(2'd3, 32'd0, "w1c_clears");
    expect_irq(1'b0, "irq_after_clear");

    // Reset mid-debounce with bit 3 held
    in_port = 4'h8;
    tick(MID);
    reset_n = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) expect_reg(2'(a), 32'd0, "mid_reset_read");
    expect_irq(1'b0, "mid_reset_irq");
    tick(2);
    reset_n = 1'b1;
    tick(LAT - 1);
    expect_reg(2'd0, 32'd0, "rst_data_before_latency");
    tick(1);
    expect_reg(2'd0, 32'h8, "rst_data_at_latency");
    tick(1);
    expect_reg(2'd3, 32'h8, "rst_single_capture");
    expect_irq(1'b0, "rst_mask_cleared");
    wr(2'd3, 32'h8);
    tick(10);
    expect_reg(2'd3, 32'd0, "no_second_capture");
    expect_reg(2'd0, 32'h8, "held_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
